// File: rtl/seg7_pkg.sv
// Glyph codes and the glyph-to-segment decoder shared by the scrolling display driver.
// Segment bytes are abcdefgh (a = bit 7, dp = bit 0), active-low.
package seg7_pkg;

    typedef logic [4:0] glyph_t;

    localparam glyph_t G_0     = 5'h00;
    localparam glyph_t G_1     = 5'h01;
    localparam glyph_t G_2     = 5'h02;
    localparam glyph_t G_3     = 5'h03;
    localparam glyph_t G_4     = 5'h04;
    localparam glyph_t G_5     = 5'h05;
    localparam glyph_t G_6     = 5'h06;
    localparam glyph_t G_7     = 5'h07;
    localparam glyph_t G_8     = 5'h08;
    localparam glyph_t G_9     = 5'h09;
    localparam glyph_t G_A     = 5'h0A;
    localparam glyph_t G_B     = 5'h0B;
    localparam glyph_t G_C     = 5'h0C;
    localparam glyph_t G_D     = 5'h0D;
    localparam glyph_t G_E     = 5'h0E;
    localparam glyph_t G_F     = 5'h0F;
    localparam glyph_t G_H     = 5'h10;
    localparam glyph_t G_L     = 5'h11;
    localparam glyph_t G_P     = 5'h12;
    localparam glyph_t G_U     = 5'h13;
    localparam glyph_t G_MINUS = 5'h14;
    localparam glyph_t G_BLANK = 5'h1F;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] glyph_to_seg(input glyph_t g);
        logic [7:0] r_seg;
        case (g)
            G_0:     r_seg = 8'b0000_0011;
            G_1:     r_seg = 8'b1001_1111;
            G_2:     r_seg = 8'b0010_0101;
            G_3:     r_seg = 8'b0000_1101;
            G_4:     r_seg = 8'b1001_1001;
            G_5:     r_seg = 8'b0100_1001;
            G_6:     r_seg = 8'b0100_0001;
            G_7:     r_seg = 8'b0001_1111;
            G_8:     r_seg = 8'b0000_0001;
            G_9:     r_seg = 8'b0000_1001;
            G_A:     r_seg = 8'b0001_0001;
            G_B:     r_seg = 8'b1100_0001;
            G_C:     r_seg = 8'b0110_0011;
            G_D:     r_seg = 8'b1000_0101;
            G_E:     r_seg = 8'b0110_0001;
            G_F:     r_seg = 8'b0111_0001;
            G_H:     r_seg = 8'b1001_0001;
            G_L:     r_seg = 8'b1110_0011;
            G_P:     r_seg = 8'b0011_0001;
            G_U:     r_seg = 8'b1000_0011;
            G_MINUS: r_seg = 8'b1111_1101;
            default: r_seg = SEG_BLANK;
        endcase
        return r_seg;
    endfunction

endpackage

// File: rtl/strobe_gen.sv
// Free-running timebase: one-cycle strobe each time the count wraps at PERIOD-1.
module strobe_gen #(
    parameter int PERIOD = 4096
) (
    input  logic clk,
    input  logic reset_n,
    output logic strobe
);

    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;

    assign strobe = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (strobe)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/seg7_scroll_driver.sv
// Buffers a glyph message from a valid/ready stream, then scrolls it right-to-left
// across a 4-digit multiplexed 7-segment display followed by four blank positions.
module seg7_scroll_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_PERIOD  = 4096,
    parameter int SCROLL_PERIOD = 8388608,
    parameter int MSG_LEN       = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_char,
    input  logic       in_last,
    output logic       busy,
    output logic [7:0] abcdefgh,
    output logic [3:0] digit
);

    localparam int LEN_W = $clog2(MSG_LEN + 1);
    localparam int ADR_W = $clog2(MSG_LEN);
    localparam int POS_W = $clog2(MSG_LEN + 4) + 1;

    localparam logic [0:0] S_LOAD   = 1'b0;
    localparam logic [0:0] S_SCROLL = 1'b1;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MSG_LEN);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MSG_LEN - 1);

    logic [0:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [POS_W-1:0] r_offset;
    logic [1:0]       r_idx;
    logic             r_upd;
    logic [7:0]       r_seg;
    logic [3:0]       r_dig;
    glyph_t           r_buf [MSG_LEN];

    logic             w_mux_stb;
    logic             w_scr_stb;
    logic             w_accept;
    logic [POS_W-1:0] w_seq_len;
    logic [POS_W-1:0] w_sum;
    logic [POS_W-1:0] w_pos;
    logic             w_blank;
    glyph_t           w_glyph;

    strobe_gen #(.PERIOD(DIGIT_PERIOD)) u_mux_tb (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (w_mux_stb)
    );

    strobe_gen #(.PERIOD(SCROLL_PERIOD)) u_scroll_tb (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (w_scr_stb)
    );

    assign in_ready = (r_state == S_LOAD) && (r_len < LEN_MAX);
    assign busy     = (r_state == S_SCROLL);
    assign w_accept = in_valid && in_ready && !restart;

    // Window position r_idx reads seq[(offset + idx) mod (len + 4)]; one subtraction suffices.
    assign w_seq_len = POS_W'(r_len) + POS_W'(4);
    assign w_sum     = r_offset + POS_W'(r_idx);
    assign w_pos     = (w_sum >= w_seq_len) ? (w_sum - w_seq_len) : w_sum;
    assign w_blank   = (r_state == S_LOAD) || restart || (w_pos >= POS_W'(r_len));
    assign w_glyph   = r_buf[w_pos[ADR_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_LOAD;
            r_len    <= '0;
            r_offset <= '0;
        end else if (restart) begin
            r_state  <= S_LOAD;
            r_len    <= '0;
            r_offset <= '0;
        end else if (r_state == S_LOAD) begin
            if (w_accept) begin
                r_len <= r_len + 1'b1;
                if (in_last || (r_len == LEN_LAST))
                    r_state <= S_SCROLL;
            end
        end else if (w_scr_stb) begin
            r_offset <= (r_offset == (w_seq_len - 1'b1)) ? '0 : (r_offset + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_buf[r_len[ADR_W-1:0]] <= in_char;
    end

    // The output pair reloads the cycle after any index or offset change, so digit and glyph always match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_upd <= 1'b0;
            r_seg <= SEG_BLANK;
            r_dig <= 4'hF;
        end else begin
            r_upd <= w_mux_stb || w_scr_stb;
            if (w_mux_stb)
                r_idx <= r_idx + 2'd1;
            if (r_upd) begin
                r_dig <= ~(4'b1000 >> r_idx);
                r_seg <= w_blank ? SEG_BLANK : glyph_to_seg(w_glyph);
            end
        end
    end

    assign abcdefgh = r_seg;
    assign digit    = r_dig;

endmodule
